// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, load/store funct3 encodings, MEM stage FSM states.
package core_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_BITS = 3;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam logic [OPC_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE = 7'b0100011;

  localparam logic [F3_BITS-1:0] F3_B  = 3'd0;
  localparam logic [F3_BITS-1:0] F3_H  = 3'd1;
  localparam logic [F3_BITS-1:0] F3_W  = 3'd2;
  localparam logic [F3_BITS-1:0] F3_BU = 3'd4;
  localparam logic [F3_BITS-1:0] F3_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the MEM stage: byte enables, store replication,
// load extraction/extension and misalignment detection.
module mem_align
  import core_pkg::*;
(
  input  logic [F3_BITS-1:0] f3,
  input  logic [OFF_W-1:0]   off,
  input  logic [DATA_W-1:0]  store_data,
  input  logic [DATA_W-1:0]  rdata,
  output logic [BE_W-1:0]    be,
  output logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  load_data,
  output logic               misaligned
);

  logic [DATA_W-1:0] shifted;

  // Unlisted funct3 values fall through to full-word behaviour.
  always_comb begin
    shifted    = rdata >> {off, 3'b000};
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = shifted;
    misaligned = 1'b0;
    case (f3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
        if (f3 == F3_B) begin
          load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
        end else begin
          load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
        end
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << off;
        wdata      = {2{store_data[15:0]}};
        misaligned = off[0];
        if (f3 == F3_H) begin
          load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
        end else begin
          load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
        end
      end
      default: begin
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: drives the single-outstanding req/ack data bus for loads
// and stores and produces the MEM/WB register plus an upstream stall.
module mem_stage
  import core_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_mem_valid,
  input  logic [XLEN-1:0] ex_mem_ir,
  input  logic [XLEN-1:0] ex_mem_cond,
  input  logic [XLEN-1:0] ex_mem_alu,
  input  logic [XLEN-1:0] ex_mem_b,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            mem_wb_valid,
  output logic [XLEN-1:0] mem_wb_ir,
  output logic [XLEN-1:0] mem_wb_alu,
  output logic [XLEN-1:0] mem_wb_lmd,
  output logic [XLEN-1:0] mem_wb_cond,
  output logic            misalign_exc,
  output logic            bus_err
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  mem_state_t          state;
  mem_state_t          state_next;
  logic [CNT_W-1:0]    wait_cnt;

  logic [OPC_W-1:0]    opcode;
  logic [F3_BITS-1:0]  f3;
  logic [F3_BITS-1:0]  align_f3;
  logic                is_load;
  logic                is_store;
  logic                is_mem;
  logic                go;
  logic                at_limit;

  logic [BE_W-1:0]     al_be;
  logic [DATA_W-1:0]   al_wdata;
  logic [DATA_W-1:0]   al_load;
  logic                al_misaligned;

  logic                complete;
  logic                timeout;
  logic                squash;

  assign opcode   = ex_mem_ir[6:0];
  assign f3       = ex_mem_ir[14:12];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_load | is_store;
  // Stores only define B/H/W; anything else is treated as a word store.
  assign align_f3 = (is_store && (f3 > F3_W)) ? F3_W : f3;
  assign go       = ex_mem_valid & is_mem & ~al_misaligned;
  // The IDLE request cycle already counts as one cycle of waiting.
  assign at_limit = (wait_cnt >= CNT_W'(MAX_WAIT - 1));

  mem_align u_align (
    .f3         (align_f3),
    .off        (ex_mem_alu[1:0]),
    .store_data (ex_mem_b),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (go && !dmem_ack) state_next = WAIT;
      WAIT: if (dmem_ack || at_limit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    squash    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          dmem_req  = 1'b1;
          mem_stall = ~dmem_ack;
          complete  = dmem_ack;
        end else if (ex_mem_valid && !is_mem) begin
          complete = 1'b1;
        end
        squash = ex_mem_valid & is_mem & al_misaligned;
      end
      WAIT: begin
        dmem_req  = 1'b1;
        mem_stall = ~dmem_ack;
        complete  = dmem_ack;
        timeout   = ~dmem_ack & at_limit;
      end
      default: ;
    endcase
    // An in-flight access is abandoned the moment reset rises.
    if (reset) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  assign dmem_we    = dmem_req & is_store;
  assign dmem_be    = dmem_req ? al_be : 4'b0000;
  assign dmem_addr  = {ex_mem_alu[XLEN-1:2], 2'b00};
  assign dmem_wdata = al_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_next == WAIT) begin
      wait_cnt <= (state == IDLE) ? CNT_W'(1) : wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // MEM/WB register; fields hold across bubbles, only valid is cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wb_valid <= 1'b0;
      mem_wb_ir    <= '0;
      mem_wb_alu   <= '0;
      mem_wb_lmd   <= '0;
      mem_wb_cond  <= '0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      mem_wb_valid <= complete;
      misalign_exc <= squash;
      bus_err      <= timeout;
      if (complete) begin
        mem_wb_ir   <= ex_mem_ir;
        mem_wb_alu  <= ex_mem_alu;
        mem_wb_cond <= ex_mem_cond;
        mem_wb_lmd  <= is_load ? al_load : '0;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage 4 (MEM) of the 5-stage RV32I core. It sits directly downstream of the execute stage and consumes the EX/MEM register: IR, COND, ALU output and register B.
- Loads and stores go out on a single-outstanding req/ack data-memory bus; this covers byte-lane steering, load sign/zero extension, misalignment detection and a bus-timeout watchdog.
- It produces the MEM/WB register for writeback and a stall to the upstream stages.

Parameters:
- MAX_WAIT, 16, cycles in WAIT without dmem_ack before a bus error is raised (must be >= 1).
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_mem_valid  in  1  EX/MEM holds a live instruction.
- ex_mem_ir  in  32  instruction word.
- ex_mem_cond  in  32  branch condition; passed through.
- ex_mem_alu  in  32  ALU result, which is the effective address for loads/stores.
- ex_mem_b  in  32  register B, the store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address, {ex_mem_alu[31:2], 2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  request accepted/completed; rdata valid the same cycle.
- dmem_rdata  in  32  read word.
- mem_stall  out  1  hold IF/ID/EX and EX/MEM this cycle.
- mem_wb_valid  out  1  MEM/WB holds a live instruction.
- mem_wb_ir  out  32  instruction word.
- mem_wb_alu  out  32  ALU result.
- mem_wb_lmd  out  32  extended load data; 0 for non-loads.
- mem_wb_cond  out  32  passthrough of COND.
- misalign_exc  out  1  one-cycle pulse: misaligned access squashed.
- bus_err  out  1  one-cycle pulse: MAX_WAIT expired.

Behaviour:
- Reset (async): state=IDLE, wait counter=0, all mem_wb_* =0, misalign_exc=0, bus_err=0.
- Decode:
  - load = opcode 0000011; store = opcode 0100011.
  - f3 = ir[14:12]; byte off = alu[1:0].
- Alignment:
  - Half requires off[0]=0; word requires off=00.
  - Byte is always aligned.
- dmem_be:
  - SB: 1<<off.
  - SH: 0011<<off.
  - SW: 1111.
  - Loads use the same mask.
- dmem_wdata:
  - SB: {4{b[7:0]}}.
  - SH: {2{b[15:0]}}.
  - SW: b.
- Load extract:
  - Shift rdata right by 8*off.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW as is.
  - Undefined f3 treated as LW/SW.
- FSM IDLE:
  - Valid, aligned mem op: dmem_req=1 combinationally, with addr/we/be/wdata valid.
    - If dmem_ack is high the same cycle, complete with zero wait: MEM/WB loads, no stall.
    - Otherwise mem_stall=1 and go to WAIT, counter=1.
  - Valid non-mem op: MEM/WB loads at the next edge; lmd=0; no bus activity.
  - Misaligned mem op: no request. Next edge: misalign_exc=1, mem_wb_valid=0 (instruction squashed).
  - Not valid: mem_wb_valid<=0.
- FSM WAIT:
  - dmem_req held at 1, with addr/we/be/wdata stable; mem_stall=1 except in the ack cycle.
  - Each cycle, mem_wb_valid<=0 (bubble).
  - dmem_ack: complete (MEM/WB loads, lmd from rdata for loads), stall low, return to IDLE.
  - Counter reaching MAX_WAIT without ack: drop req, bus_err pulse, bubble, return to IDLE.
- ack while req=0 is ignored.
- ack in the same cycle as the timeout: the ack wins.
- Upstream holds EX/MEM stable while mem_stall=1.
- Stores write mem_wb_lmd=0.
- Reset mid-WAIT aborts the access immediately: req=0, state IDLE.

Decomposition:
- Shared package core_pkg: opcode constants OP_LOAD/OP_STORE, funct3 encodings (F3_B/H/W/BU/HU), and mem_state_t enum {IDLE, WAIT}.
- One sub-module, mem_align (combinational): takes f3, off, store data and rdata; returns be, wdata, extended load data and a misaligned flag.

Test Plan:
- Reset asserted mid-WAIT, async, with no clock edge → dmem_req=0 and all mem_wb_* =0 immediately; on release, state is IDLE.
- SW alu=0x100, b=0xDEADBEEF, ack same cycle → addr 0x100, be=1111, wdata=0xDEADBEEF, mem_stall never high, mem_wb_valid=1 next edge.
- LB alu=0x203, rdata=0x80FF_1234, ack after 3 cycles → mem_stall high 3 cycles, three bubbles, then lmd=0xFFFFFF80; the LBU variant gives 0x00000080.
- SH alu=0x102, b=0x0000ABCD → be=1100, wdata=0xABCDABCD; LH alu=0x101 → no req, misalign_exc pulse, mem_wb_valid=0.
- LW with ack withheld and MAX_WAIT=4 → req high 4 cycles, bus_err pulse, req drops, stall releases; an ack arriving in cycle 4 instead completes normally.
- ADD passthrough ir=0x003100B3, alu=0x5, cond=0 → mem_wb_ir/alu copied next edge, lmd=0, dmem_req=0 throughout.
